// File: rtl/ballot_sequencer.sv
// Ballot sequencer: arms one voter, turns a single rising button edge into a one-cycle
// vote strobe, then locks out. Optional ARMED timeout enabled by `define ARM_TIMEOUT_EN.
module ballot_sequencer #(
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_sw,
  input  logic       arm,
  input  logic [4:1] button,
  output logic [4:1] vote_pulse,
  output logic       logger_mode,
  output logic       ready,
  output logic [1:0] display_sel,
  output logic       conflict_pulse,
  output logic       timeout_pulse,
  output logic [7:0] ballots_cast
);

  localparam int unsigned CNT_MAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
`ifdef ARM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIME_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAST,
    S_LOCKOUT,
    S_RESULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:1]       btn_prev_q;
  logic [1:0]       idx_q, idx_d;
  logic [4:1]       vote_q, vote_d;
  logic             logger_q, logger_d;
  logic             ready_q, ready_d;
  logic [1:0]       disp_q, disp_d;
  logic             conflict_q, conflict_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       ballots_q, ballots_d;

  logic [4:1]       rise;
  logic             any_rise;
  logic             multi_rise;
  logic [1:0]       low_idx;

  assign rise       = button & ~btn_prev_q;
  assign any_rise   = |rise;
  assign multi_rise = |(rise & (rise - 4'd1));

  // Lowest pressed index; scanning downward lets the lowest set bit win.
  always_comb begin
    low_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      if (rise[k]) low_idx = 2'(k - 1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    vote_d     = 4'b0000;
    disp_d     = disp_q;
    conflict_d = 1'b0;
    timeout_d  = 1'b0;
    ballots_d  = ballots_q;
    case (state_q)
      S_IDLE: begin
        if (mode_sw) begin
          state_d = S_RESULT;
        end else if (arm) begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end
      end
      S_ARMED: begin
        if (mode_sw) begin
          state_d = S_RESULT;
        end else if (any_rise && !multi_rise) begin
          idx_d   = low_idx;
          state_d = S_CAST;
        end else begin
          conflict_d = multi_rise;
`ifdef ARM_TIMEOUT_EN
          // Conflicts fall through here, so they keep aging the authorisation.
          if (cnt_q == TIME_LAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      S_CAST: begin
        vote_d = 4'(4'b0001 << idx_q);
        if (ballots_q != 8'hFF) ballots_d = ballots_q + 8'd1;
        cnt_d   = '0;
        state_d = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (cnt_q == LOCK_LAST) begin
          state_d = mode_sw ? S_RESULT : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESULT: begin
        if (any_rise) disp_d = low_idx;
        if (!mode_sw) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d  = (state_d == S_ARMED);
    logger_d = (state_d == S_RESULT);
  end

  // Previous-button register resets high so buttons held through reset are not presses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      btn_prev_q <= 4'b1111;
      idx_q      <= 2'd0;
      vote_q     <= 4'b0000;
      logger_q   <= 1'b0;
      ready_q    <= 1'b0;
      disp_q     <= 2'd0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      ballots_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= button;
      idx_q      <= idx_d;
      vote_q     <= vote_d;
      logger_q   <= logger_d;
      ready_q    <= ready_d;
      disp_q     <= disp_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
      ballots_q  <= ballots_d;
    end
  end

  assign vote_pulse     = vote_q;
  assign logger_mode    = logger_q;
  assign ready          = ready_q;
  assign display_sel    = disp_q;
  assign conflict_pulse = conflict_q;
  assign timeout_pulse  = timeout_q;
  assign ballots_cast   = ballots_q;

endmodule

// File: tb/tb_ballot_sequencer.sv
// Scoreboard bench for ballot_sequencer: directed scenarios plus random stimulus checked
// against a voter-level reference model.
module tb_ballot_sequencer;

  localparam int unsigned LOCK = 16;
  localparam int unsigned TOUT = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode_sw;
  logic       arm;
  logic [4:1] button;
  logic [4:1] vote_pulse;
  logic       logger_mode;
  logic       ready;
  logic [1:0] display_sel;
  logic       conflict_pulse;
  logic       timeout_pulse;
  logic [7:0] ballots_cast;

  always #5 clock = ~clock;

  ballot_sequencer #(
    .LOCKOUT_CYCLES(LOCK),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mode_sw        (mode_sw),
    .arm            (arm),
    .button         (button),
    .vote_pulse     (vote_pulse),
    .logger_mode    (logger_mode),
    .ready          (ready),
    .display_sel    (display_sel),
    .conflict_pulse (conflict_pulse),
    .timeout_pulse  (timeout_pulse),
    .ballots_cast   (ballots_cast)
  );

  typedef struct {
    logic [4:1] vote;
    logic       conf;
    logic       tout;
    logic       rdy;
    logic       logm;
    logic [1:0] disp;
    int         ballots;
  } exp_t;

  typedef struct {
    logic [4:1] vote;
    int         ballots;
  } vote_t;

  exp_t  exp_q[$];
  vote_t vote_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Voter-level model: an authorisation flag, a pending ballot, a lockout countdown,
  // a viewing flag and an authorisation age.
  logic [4:1] m_prev = 4'b1111;
  bit         m_auth;
  bit         m_view;
  int         m_pending = -1;
  int         m_lock;
  int         m_age;
  int         m_ballots;
  logic [1:0] m_disp;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic m, input logic a, input logic [4:1] b);
    logic [4:1] rise;
    exp_t       e;
    int         presses;
    rise   = b & ~m_prev;
    m_prev = b;
    e.vote = 4'b0000;
    e.conf = 1'b0;
    e.tout = 1'b0;
    if (r) begin
      m_prev    = 4'b1111;
      m_auth    = 1'b0;
      m_view    = 1'b0;
      m_pending = -1;
      m_lock    = 0;
      m_age     = 0;
      m_ballots = 0;
      m_disp    = 2'd0;
    end else begin
      presses = $countones(rise);
      if (m_pending >= 0) begin
        e.vote    = 4'(1 << m_pending);
        m_ballots = (m_ballots < 255) ? m_ballots + 1 : 255;
        m_pending = -1;
        m_lock    = LOCK;
      end else if (m_lock > 0) begin
        m_lock--;
        if (m_lock == 0) m_view = m;
      end else if (m_view) begin
        for (int k = 4; k >= 1; k--) if (rise[k]) m_disp = 2'(k - 1);
        if (!m) m_view = 1'b0;
      end else if (m_auth) begin
        if (m) begin
          m_auth = 1'b0;
          m_view = 1'b1;
        end else if (presses == 1) begin
          for (int k = 1; k <= 4; k++) if (rise[k]) m_pending = k - 1;
          m_auth = 1'b0;
        end else begin
          e.conf = (presses >= 2);
`ifdef ARM_TIMEOUT_EN
          m_age++;
          if (m_age == TOUT) begin
            m_auth = 1'b0;
            e.tout = 1'b1;
          end
`endif
        end
      end else begin
        if (m) m_view = 1'b1;
        else if (a) begin
          m_auth = 1'b1;
          m_age  = 0;
        end
      end
    end
    e.rdy     = m_auth;
    e.logm    = m_view;
    e.disp    = m_disp;
    e.ballots = m_ballots;
    exp_q.push_back(e);
    if (e.vote != 4'b0000) vote_q.push_back('{e.vote, m_ballots});
  endtask

  // Monitor: vote strobes pop the vote scoreboard; every cycle pops the status record.
  initial begin
    exp_t  e;
    vote_t v;
    forever begin
      @(negedge clock);
      if (vote_pulse != 4'b0000) begin
        if (vote_q.size() == 0) begin
          check("unexpected_vote", int'(vote_pulse), 0);
        end else begin
          v = vote_q.pop_front();
          check("vote_pulse", int'(vote_pulse), int'(v.vote));
          check("ballots_at_vote", int'(ballots_cast), v.ballots);
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("vote_pulse_cycle", int'(vote_pulse), int'(e.vote));
        check("conflict_pulse", int'(conflict_pulse), int'(e.conf));
        check("timeout_pulse", int'(timeout_pulse), int'(e.tout));
        check("ready", int'(ready), int'(e.rdy));
        check("logger_mode", int'(logger_mode), int'(e.logm));
        check("display_sel", int'(display_sel), int'(e.disp));
        check("ballots_cast", int'(ballots_cast), e.ballots);
      end
    end
  end

  task automatic step(input logic r, input logic m, input logic a, input logic [4:1] b);
    reset   = r;
    mode_sw = m;
    arm     = a;
    button  = b;
    @(posedge clock);
    model_step(r, m, a, b);
    #1;
  endtask

  task automatic idle(input int n, input logic m);
    repeat (n) step(1'b0, m, 1'b0, 4'b0000);
  endtask

  task automatic ballot(input int k);
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'(1 << k));
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    idle(LOCK + 1, 1'b0);
  endtask

  initial begin
    logic       cur_mode;
    logic [4:1] b;
    // Reset with button[3] held: no press once released from reset.
    step(1'b1, 1'b0, 1'b0, 4'b0100);
    step(1'b1, 1'b0, 1'b0, 4'b0100);
    step(1'b0, 1'b0, 1'b1, 4'b0100);
    step(1'b0, 1'b0, 1'b0, 4'b0100);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0100);
    idle(LOCK + 3, 1'b0);

    // Simultaneous press conflict, then a clean button[2] press.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0011);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0010);
    idle(LOCK + 3, 1'b0);

    // Press in IDLE; press and arm during LOCKOUT.
    step(1'b0, 1'b0, 1'b0, 4'b1000);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0001);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 4'(i[0] ? 4'b0001 : 4'b0100));
    idle(LOCK, 1'b0);

    // Result viewing from ARMED, button[4] selects candidate 3.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b1, 1'b0, 4'b1000);
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'b0110);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    idle(2, 1'b0);

    // mode_sw rising during CAST/LOCKOUT still completes the ballot.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b1000);
    idle(LOCK + 3, 1'b1);
    idle(2, 1'b0);

    // Armed with no press for longer than the timeout window.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    idle(TOUT + 6, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0001);
    idle(LOCK + 3, 1'b0);

    // Saturation of the ballot counter.
    for (int i = 0; i < 260; i++) ballot(i % 4);

    // Reset while in CAST suppresses the vote.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0100);
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    idle(3, 1'b0);

    // Randomised traffic.
    cur_mode = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 40) == 0) cur_mode = ~cur_mode;
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step(1'($urandom_range(0, 600) == 0), cur_mode, 1'($urandom_range(0, 5) == 0), b);
    end

    idle(LOCK + 3, 1'b0);
    @(negedge clock);
    #1;
    check("vote_queue_drained", vote_q.size(), 0);
    check("status_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ballot_sequencer.md
BALLOT_SEQUENCER -- requirements
Module: ballot_sequencer

Interface
REQ-001 SHALL have parameter LOCKOUT_CYCLES, default 16: cycles spent in LOCKOUT after each accepted ballot, at least 1.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: ARMED idle limit when ARM_TIMEOUT_EN is defined, at least 1.
REQ-003 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mode_sw, input, 1 bit: 0 = voting session, 1 = result viewing.
REQ-006 SHALL have port arm, input, 1 bit: officer authorisation for exactly one voter.
REQ-007 SHALL have port button[4:1], input, 4 bits: debounced candidate button levels.
REQ-008 SHALL have port vote_pulse[4:1], output, 4 bits: one-hot, one-cycle valid-vote strobe to the vote counter.
REQ-009 SHALL have port logger_mode, output, 1 bit: mode driven to the vote counter; 1 only in RESULT.
REQ-010 SHALL have port ready, output, 1 bit: 1 only in ARMED (voter may press).
REQ-011 SHALL have port display_sel[1:0], output, 2 bits: candidate index (0..3) shown in RESULT.
REQ-012 SHALL have port conflict_pulse, output, 1 bit: one-cycle flag for a rejected multi-press.
REQ-013 SHALL have port timeout_pulse, output, 1 bit: one-cycle flag for an expired authorisation.
REQ-014 SHALL have port ballots_cast[7:0], output, 8 bits: total accepted ballots, saturating at 255.

Function
REQ-015 SHALL detect button rising edges against a registered previous value; only rising edges count as presses.
REQ-016 SHALL implement the states IDLE, ARMED, CAST, LOCKOUT and RESULT; all outputs are registered.
REQ-017 SHALL, in IDLE, go to RESULT if mode_sw=1; otherwise go to ARMED if arm=1.
REQ-018 SHALL, in ARMED, on exactly one rising edge with mode_sw=0, latch that index and go to CAST.
REQ-019 SHALL, in ARMED, on two or more simultaneous rising edges, stay in ARMED, record no vote, and assert conflict_pulse for one cycle.
REQ-020 SHALL, in ARMED with mode_sw=1, discard the authorisation and go to RESULT; mode_sw takes priority over a same-cycle press.
REQ-021 SHALL, in CAST, assert vote_pulse for exactly one cycle, one cycle after the edge at which the press was sampled.
REQ-022 SHALL, in CAST, increment ballots_cast with saturation at 255 and go to LOCKOUT.
REQ-023 SHALL, in LOCKOUT, ignore arm and button for LOCKOUT_CYCLES cycles, then go to RESULT if mode_sw=1, else to IDLE.
REQ-024 SHALL complete CAST and LOCKOUT even if mode_sw rises during them.
REQ-025 SHALL hold logger_mode=1 in RESULT; a rising edge on button[k] sets display_sel=k-1, the lowest index winning on a multi-press; no vote_pulse is issued.
REQ-026 SHALL, in RESULT, return to IDLE when mode_sw=0, keeping display_sel.
REQ-027 SHALL ignore arm whenever the state is not IDLE; arm is never queued.
REQ-028 SHALL keep vote_pulse at 0 outside CAST and never assert more than one of its bits.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, set state IDLE; vote_pulse, logger_mode, ready, display_sel, conflict_pulse, timeout_pulse and ballots_cast to 0; and all counters to 0.
REQ-030 SHALL reset the previous-button register to 4'b1111, so a button held through reset produces no press.
REQ-031 SHALL give reset priority over all other inputs; reset in CAST suppresses the vote_pulse.

Configuration
REQ-032 SHALL, when ARM_TIMEOUT_EN is defined, return ARMED to IDLE after TIMEOUT_CYCLES consecutive cycles without an accepted press, asserting timeout_pulse for one cycle; conflicts do not restart the count.
REQ-033 SHALL, when ARM_TIMEOUT_EN is undefined, stay in ARMED indefinitely, keep the timeout_pulse port, and tie it to 0.

Verification
REQ-034 SHALL cover: arm pulse, then button[3] rises -> vote_pulse=4'b0100 for one cycle, ballots_cast 0->1, ready low through 16 LOCKOUT cycles, then IDLE.
REQ-035 SHALL cover: armed, button[1] and button[2] rise in the same cycle -> conflict_pulse=1, vote_pulse stays 0; a later button[2] rise -> vote_pulse=4'b0010.
REQ-036 SHALL cover: a button press in IDLE or LOCKOUT, and arm during LOCKOUT -> no vote_pulse and no change to ballots_cast.
REQ-037 SHALL cover: mode_sw=1 while ARMED -> logger_mode=1, ready=0; a button[4] rise -> display_sel=3 with no vote_pulse; mode_sw=0 -> IDLE.
REQ-038 SHALL cover: 260 armed ballots -> ballots_cast holds at 255; reset asserted in CAST -> no pulse, all outputs 0.
REQ-039 SHALL cover, with ARM_TIMEOUT_EN defined and TIMEOUT_CYCLES=8: arm, no press -> timeout_pulse after 8 cycles, state IDLE; with the macro undefined, ready stays 1.
